// File: rtl/sd_scoreboard_arb_if.sv
// Bundle of client, response and FSM-side handshake signals for sd_scoreboard_arb.
// master is the arbiter's view; slave is the view of the clients plus the scoreboard FSM.
interface sd_scoreboard_arb_if #(
   parameter int width   = 8,
   parameter int items   = 64,
   parameter int ports   = 4,
   parameter int txid_sz = 2,
   parameter int asz     = $clog2(items)
);
   logic [ports-1:0]       c_srdy;
   logic [ports-1:0]       c_drdy;
   logic [ports-1:0]       c_req_type;
   logic [ports*width-1:0] c_mask;
   logic [ports*width-1:0] c_data;
   logic [ports*asz-1:0]   c_itemid;

   logic [ports-1:0]       p_srdy;
   logic [ports-1:0]       p_drdy;
   logic [ports*width-1:0] p_data;

   logic                   ip_srdy;
   logic                   ip_drdy;
   logic                   ip_req_type;
   logic [txid_sz-1:0]     ip_txid;
   logic [width-1:0]       ip_mask;
   logic [width-1:0]       ip_data;
   logic [asz-1:0]         ip_itemid;

   logic                   ic_srdy;
   logic                   ic_drdy;
   logic [txid_sz-1:0]     ic_txid;
   logic [width-1:0]       ic_data;

   modport master (
      input  c_srdy, c_req_type, c_mask, c_data, c_itemid,
      input  p_drdy, ip_drdy, ic_srdy, ic_txid, ic_data,
      output c_drdy, p_srdy, p_data,
      output ip_srdy, ip_req_type, ip_txid, ip_mask, ip_data, ip_itemid,
      output ic_drdy
   );

   modport slave (
      output c_srdy, c_req_type, c_mask, c_data, c_itemid,
      output p_drdy, ip_drdy, ic_srdy, ic_txid, ic_data,
      input  c_drdy, p_srdy, p_data,
      input  ip_srdy, ip_req_type, ip_txid, ip_mask, ip_data, ip_itemid,
      input  ic_drdy
   );
endinterface

// File: rtl/sd_scoreboard_arb.sv
// Round-robin multi-client front end for the scoreboard FSM: one request holding
// register toward the FSM, one response slot per client, one outstanding read per client.
module sd_scoreboard_arb #(
   parameter int width   = 8,
   parameter int items   = 64,
   parameter int ports   = 4,
   parameter int txid_sz = 2,
   parameter int asz     = $clog2(items)
) (
   input logic                 clk,
   input logic                 reset,
   sd_scoreboard_arb_if.master bus
);
   typedef logic [txid_sz-1:0] idx_t;
   typedef logic [txid_sz:0]   wide_t;

   logic [ports-1:0] pend;
   idx_t             rr_ptr;
   logic [ports-1:0] eligible;
   logic             can_load;
   logic             found;
   logic             grant;
   idx_t             grant_idx;
   wide_t            probe;
   logic [ports-1:0] c_drdy_c;

   logic             sel_type;
   logic [width-1:0] sel_mask;
   logic [width-1:0] sel_data;
   logic [asz-1:0]   sel_itemid;

   logic             ip_srdy_q;
   logic             ip_req_type_q;
   idx_t             ip_txid_q;
   logic [width-1:0] ip_mask_q;
   logic [width-1:0] ip_data_q;
   logic [asz-1:0]   ip_itemid_q;

   logic [ports-1:0] p_srdy_q;
   logic [width-1:0] p_data_q [ports];
   logic             ic_valid_id;
   logic             ic_slot_free;
   logic             ic_drdy_c;
   logic             ic_load;

   assign eligible = bus.c_srdy & ~pend;
   assign can_load = !ip_srdy_q || bus.ip_drdy;

   // Search eligible clients starting at rr_ptr, wrapping modulo ports.
   always_comb begin
      found     = 1'b0;
      grant_idx = '0;
      probe     = '0;
      for (int k = 0; k < ports; k++) begin
         probe = {1'b0, rr_ptr} + wide_t'(k);
         if (probe >= wide_t'(ports)) probe = probe - wide_t'(ports);
         for (int i = 0; i < ports; i++) begin
            if (!found && probe == wide_t'(i) && eligible[i]) begin
               found     = 1'b1;
               grant_idx = idx_t'(i);
            end
         end
      end
   end

   assign grant = can_load && found;

   always_comb begin
      c_drdy_c   = '0;
      sel_type   = 1'b0;
      sel_mask   = '0;
      sel_data   = '0;
      sel_itemid = '0;
      for (int i = 0; i < ports; i++) begin
         if (grant_idx == idx_t'(i)) begin
            c_drdy_c[i] = grant;
            sel_type    = bus.c_req_type[i];
            sel_mask    = bus.c_mask[i*width +: width];
            sel_data    = bus.c_data[i*width +: width];
            sel_itemid  = bus.c_itemid[i*asz +: asz];
         end
      end
   end

   assign bus.c_drdy = c_drdy_c;

   // NOTE: all sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ip_srdy_q     <= 1'b0;
         ip_req_type_q <= 1'b0;
         ip_txid_q     <= '0;
         ip_mask_q     <= '0;
         ip_data_q     <= '0;
         ip_itemid_q   <= '0;
         rr_ptr        <= '0;
      end else if (grant) begin
         ip_srdy_q     <= 1'b1;
         ip_req_type_q <= sel_type;
         ip_txid_q     <= grant_idx;
         ip_mask_q     <= sel_mask;
         ip_data_q     <= sel_data;
         ip_itemid_q   <= sel_itemid;
         rr_ptr        <= (grant_idx == idx_t'(ports - 1)) ? '0 : grant_idx + 1'b1;
      end else if (bus.ip_drdy) begin
         ip_srdy_q     <= 1'b0;
      end
   end

   assign bus.ip_srdy     = ip_srdy_q;
   assign bus.ip_req_type = ip_req_type_q;
   assign bus.ip_txid     = ip_txid_q;
   assign bus.ip_mask     = ip_mask_q;
   assign bus.ip_data     = ip_data_q;
   assign bus.ip_itemid   = ip_itemid_q;

   // Out-of-range IDs are accepted and dropped so a stray response cannot wedge the FSM.
   assign ic_valid_id = {1'b0, bus.ic_txid} < wide_t'(ports);

   always_comb begin
      ic_slot_free = 1'b0;
      for (int i = 0; i < ports; i++) begin
         if (bus.ic_txid == idx_t'(i)) ic_slot_free = !p_srdy_q[i] || bus.p_drdy[i];
      end
   end

   assign ic_drdy_c   = !ic_valid_id || ic_slot_free;
   assign ic_load     = bus.ic_srdy && ic_drdy_c && ic_valid_id;
   assign bus.ic_drdy = ic_drdy_c;

   // A pending client is never eligible, so set and clear cannot collide.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend <= '0;
      end else begin
         for (int i = 0; i < ports; i++) begin
            if (grant && grant_idx == idx_t'(i) && !bus.c_req_type[i]) pend[i] <= 1'b1;
            else if (p_srdy_q[i] && bus.p_drdy[i])                      pend[i] <= 1'b0;
         end
      end
   end

   // NOTE: the response slots are reset as well, since p_data is defined as 0 out of reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         p_srdy_q <= '0;
         for (int i = 0; i < ports; i++) p_data_q[i] <= '0;
      end else begin
         for (int i = 0; i < ports; i++) begin
            if (ic_load && bus.ic_txid == idx_t'(i)) begin
               p_srdy_q[i] <= 1'b1;
               p_data_q[i] <= bus.ic_data;
            end else if (p_srdy_q[i] && bus.p_drdy[i]) begin
               p_srdy_q[i] <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      bus.p_data = '0;
      for (int i = 0; i < ports; i++) bus.p_data[i*width +: width] = p_data_q[i];
   end

   assign bus.p_srdy = p_srdy_q;
endmodule

// File: tb/tb_sd_scoreboard_arb.sv
// Directed bench for sd_scoreboard_arb: a 4-client instance for arbitration and
// response steering, and a 3-client instance for out-of-range IDs and non-power-of-2 wrap.
module tb_sd_scoreboard_arb;
   logic clk;
   logic reset;
   int   checks;
   int   errors;

   sd_scoreboard_arb_if #(.width(8), .items(64), .ports(4), .txid_sz(2)) b4 ();
   sd_scoreboard_arb_if #(.width(8), .items(64), .ports(3), .txid_sz(2)) b3 ();

   sd_scoreboard_arb #(.width(8), .items(64), .ports(4), .txid_sz(2)) dut4 (
      .clk   (clk),
      .reset (reset),
      .bus   (b4)
   );

   sd_scoreboard_arb #(.width(8), .items(64), .ports(3), .txid_sz(2)) dut3 (
      .clk   (clk),
      .reset (reset),
      .bus   (b3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic typ, input logic [5:0] item,
                          input logic [7:0] data, input logic [7:0] mask);
      b4.c_srdy[i]           = 1'b1;
      b4.c_req_type[i]       = typ;
      b4.c_itemid[i*6 +: 6]  = item;
      b4.c_data[i*8 +: 8]    = data;
      b4.c_mask[i*8 +: 8]    = mask;
   endtask

   initial begin
      int exp4 [5];
      int exp3 [4];
      exp4 = '{0, 1, 2, 3, 0};
      exp3 = '{0, 1, 2, 0};
      checks = 0;
      errors = 0;

      reset         = 1'b0;
      b4.c_srdy     = '0; b4.c_req_type = '0; b4.c_mask = '0; b4.c_data = '0; b4.c_itemid = '0;
      b4.p_drdy     = '0; b4.ip_drdy = 1'b0; b4.ic_srdy = 1'b0; b4.ic_txid = '0; b4.ic_data = '0;
      b3.c_srdy     = '0; b3.c_req_type = '0; b3.c_mask = '0; b3.c_data = '0; b3.c_itemid = '0;
      b3.p_drdy     = '0; b3.ip_drdy = 1'b0; b3.ic_srdy = 1'b0; b3.ic_txid = '0; b3.ic_data = '0;

      // Reset state
      #12;
      check("rst_ip_srdy", 32'(b4.ip_srdy), 32'h0);
      check("rst_ip_txid", 32'(b4.ip_txid), 32'h0);
      check("rst_ip_data", 32'(b4.ip_data), 32'h0);
      check("rst_p_srdy",  32'(b4.p_srdy),  32'h0);
      check("rst_p_data",  32'(b4.p_data),  32'h0);
      check("rst_c_drdy",  32'(b4.c_drdy),  32'h0);
      check("rst_ic_drdy", 32'(b4.ic_drdy), 32'h1);
      #10;
      reset = 1'b1;
      tick();

      // Round-robin: all four clients write, FSM always ready
      b4.ip_drdy = 1'b1;
      for (int i = 0; i < 4; i++) set_req(i, 1'b1, 6'(i), 8'(8'h10 + i), 8'hFF);
      for (int k = 0; k < 5; k++) begin
         #1;
         check("rr_c_drdy", 32'(b4.c_drdy), 32'(1 << exp4[k]));
         tick();
         check("rr_ip_srdy", 32'(b4.ip_srdy), 32'h1);
         check("rr_ip_txid", 32'(b4.ip_txid), 32'(exp4[k]));
         check("rr_ip_data", 32'(b4.ip_data), 32'(8'h10 + exp4[k]));
      end

      // Stall: register full with client 0, FSM not ready
      b4.ip_drdy = 1'b0;
      #1;
      check("stall_c_drdy0", 32'(b4.c_drdy), 32'h0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("stall_ip_srdy",   32'(b4.ip_srdy),   32'h1);
         check("stall_ip_txid",   32'(b4.ip_txid),   32'h0);
         check("stall_ip_data",   32'(b4.ip_data),   32'h10);
         check("stall_ip_itemid", 32'(b4.ip_itemid), 32'h0);
         check("stall_c_drdy",    32'(b4.c_drdy),    32'h0);
      end
      b4.ip_drdy = 1'b1;
      #1;
      check("unstall_c_drdy", 32'(b4.c_drdy), 32'h2);
      tick();
      check("unstall_ip_txid", 32'(b4.ip_txid), 32'h1);
      check("unstall_ip_data", 32'(b4.ip_data), 32'h11);
      b4.c_srdy = '0;
      tick();
      check("drain_ip_srdy", 32'(b4.ip_srdy), 32'h0);

      // Write passthrough: client 2, then immediate reissue shows no pend
      set_req(2, 1'b1, 6'd5, 8'hA5, 8'hFF);
      #1;
      check("wr_c_drdy", 32'(b4.c_drdy), 32'h4);
      tick();
      check("wr_ip_srdy",   32'(b4.ip_srdy),     32'h1);
      check("wr_ip_txid",   32'(b4.ip_txid),     32'h2);
      check("wr_ip_data",   32'(b4.ip_data),     32'hA5);
      check("wr_ip_itemid", 32'(b4.ip_itemid),   32'h5);
      check("wr_ip_mask",   32'(b4.ip_mask),     32'hFF);
      check("wr_ip_type",   32'(b4.ip_req_type), 32'h1);
      set_req(2, 1'b1, 6'd6, 8'hB6, 8'h0F);
      #1;
      check("wr_no_pend_c_drdy", 32'(b4.c_drdy), 32'h4);
      tick();
      check("wr2_ip_data", 32'(b4.ip_data), 32'hB6);
      check("wr2_ip_mask", 32'(b4.ip_mask), 32'h0F);
      b4.c_srdy = '0;
      tick();

      // Read round trip for client 1
      set_req(1, 1'b0, 6'd7, 8'h00, 8'h00);
      #1;
      check("rd_c_drdy", 32'(b4.c_drdy), 32'h2);
      tick();
      check("rd_ip_srdy",   32'(b4.ip_srdy),     32'h1);
      check("rd_ip_type",   32'(b4.ip_req_type), 32'h0);
      check("rd_ip_txid",   32'(b4.ip_txid),     32'h1);
      check("rd_ip_itemid", 32'(b4.ip_itemid),   32'h7);
      check("rd_pend_block", 32'(b4.c_drdy), 32'h0);
      tick();
      check("rd_ip_drained", 32'(b4.ip_srdy), 32'h0);
      b4.ic_srdy = 1'b1; b4.ic_txid = 2'd1; b4.ic_data = 8'h3C;
      #1;
      check("rsp_ic_drdy", 32'(b4.ic_drdy), 32'h1);
      tick();
      check("rsp_p_srdy", 32'(b4.p_srdy), 32'h2);
      check("rsp_p_data", 32'(b4.p_data[15:8]), 32'h3C);
      check("rsp_pend_block", 32'(b4.c_drdy), 32'h0);
      b4.ic_data = 8'h55;
      #1;
      check("rsp_full_ic_drdy", 32'(b4.ic_drdy), 32'h0);
      tick();
      check("rsp_hold_p_srdy", 32'(b4.p_srdy), 32'h2);
      check("rsp_hold_p_data", 32'(b4.p_data[15:8]), 32'h3C);
      b4.ic_srdy = 1'b0;
      b4.p_drdy  = 4'b0010;
      #1;
      check("rsp_accept_c_drdy", 32'(b4.c_drdy), 32'h0);
      tick();
      check("rsp_done_p_srdy", 32'(b4.p_srdy), 32'h0);
      check("rsp_unpend_c_drdy", 32'(b4.c_drdy), 32'h2);

      // Build up ip_srdy=1 and p_srdy[0]=1, then reset asynchronously mid-cycle
      b4.p_drdy  = '0;
      b4.ic_srdy = 1'b1; b4.ic_txid = 2'd0; b4.ic_data = 8'h99;
      tick();
      b4.c_srdy = '0; b4.ic_srdy = 1'b0; b4.ip_drdy = 1'b0;
      check("pre_rst_ip_srdy", 32'(b4.ip_srdy), 32'h1);
      check("pre_rst_p_srdy",  32'(b4.p_srdy),  32'h1);
      check("pre_rst_p_data",  32'(b4.p_data[7:0]), 32'h99);
      #2;
      reset = 1'b0;
      #1;
      check("async_rst_ip_srdy", 32'(b4.ip_srdy), 32'h0);
      check("async_rst_p_srdy",  32'(b4.p_srdy),  32'h0);
      check("async_rst_p_data",  32'(b4.p_data),  32'h0);
      check("async_rst_ip_txid", 32'(b4.ip_txid), 32'h0);
      #2;
      reset = 1'b1;
      b4.ip_drdy = 1'b1;
      for (int i = 0; i < 4; i++) set_req(i, 1'b1, 6'(i), 8'(8'h20 + i), 8'hFF);
      #1;
      check("post_rst_c_drdy", 32'(b4.c_drdy), 32'h1);
      tick();
      check("post_rst_ip_txid", 32'(b4.ip_txid), 32'h0);
      check("post_rst_unpend",  32'(b4.c_drdy),  32'h2);
      b4.c_srdy = '0;

      // 3-client instance: out-of-range response ID is swallowed
      b3.ic_srdy = 1'b1; b3.ic_txid = 2'd3; b3.ic_data = 8'hEE;
      #1;
      check("bad_id_ic_drdy", 32'(b3.ic_drdy), 32'h1);
      tick();
      check("bad_id_p_srdy", 32'(b3.p_srdy), 32'h0);
      b3.ic_txid = 2'd2; b3.ic_data = 8'h77;
      tick();
      check("p3_p_srdy", 32'(b3.p_srdy), 32'h4);
      check("p3_p_data", 32'(b3.p_data[23:16]), 32'h77);
      #1;
      check("p3_full_ic_drdy", 32'(b3.ic_drdy), 32'h0);
      b3.ic_txid = 2'd3;
      #1;
      check("bad_id_full_ic_drdy", 32'(b3.ic_drdy), 32'h1);
      tick();
      check("bad_id_hold_p_srdy", 32'(b3.p_srdy), 32'h4);
      check("bad_id_hold_p_data", 32'(b3.p_data), 32'h770000);
      b3.ic_srdy = 1'b0;

      // 3-client instance: wrap from client 2 back to client 0
      b3.ip_drdy    = 1'b1;
      b3.c_srdy     = 3'b111;
      b3.c_req_type = 3'b111;
      b3.c_data     = 24'h030201;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("rr3_c_drdy", 32'(b3.c_drdy), 32'(1 << exp3[k]));
         tick();
         check("rr3_ip_txid", 32'(b3.ip_txid), 32'(exp3[k]));
         check("rr3_ip_data", 32'(b3.ip_data), 32'(exp3[k] + 1));
      end
      b3.c_srdy = '0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
